// File: rtl/relu_maxpool_stream.sv
// 2x2 / stride-2 streaming max-pool behind the ReLU stage: raster pixels in,
// one pooled pixel per 2x2 block out, with a frame-end marker on the last one.
module relu_maxpool_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int PW       = IMG_WIDTH / 2;
  localparam int PH       = IMG_HEIGHT / 2;
  localparam int CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int RB_DEPTH = (PW > 1) ? PW : 2;
  localparam int BW       = $clog2(RB_DEPTH);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] PCOL_LAST = CW'(PW - 1);
  localparam logic [RW-1:0] PROW_LAST = RW'(PH - 1);

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic signed [DATA_WIDTH-1:0] h_q, h_d;
  logic signed [DATA_WIDTH-1:0] rb_q;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;

  logic signed [DATA_WIDTH-1:0] rowbuf [RB_DEPTH];

  logic                         accept, take, load;
  logic [CW-1:0]                pcol;
  logic [RW-1:0]                prow;
  logic signed [DATA_WIDTH-1:0] pix, hmax, pool;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign take       = accept & ~clear_i;
  assign pcol       = col_q >> 1;
  assign prow       = row_q >> 1;
  assign pix        = in_data_i;
  assign hmax       = smax(h_q, pix);
  assign pool       = smax(rb_q, hmax);
  // An odd col/odd row pixel is always inside the pooled area, so the
  // trailing column/row of an odd-sized map never reaches this path.
  assign load       = take & col_q[0] & row_q[0];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_d         = h_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (clear_i) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (!col_q[0]) h_d = pix;
      end
      if (load) begin
        out_data_d  = pool;
        out_valid_d = 1'b1;
        out_last_d  = (pcol == PCOL_LAST) && (prow == PROW_LAST);
      end else if (out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= '0;
      row_q       <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_q         <= h_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Row buffer read is prefetched on the even column of an odd row, so the
  // odd-column result only needs the registered copy in rb_q.
  always_ff @(posedge clk_i) begin
    if (take) begin
      if (!row_q[0] && col_q[0]) rowbuf[pcol[BW-1:0]] <= hmax;
      if (row_q[0] && !col_q[0]) rb_q <= rowbuf[pcol[BW-1:0]];
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (|col_q) | (|row_q) | out_valid_q;

endmodule
